// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared definitions for the quadrature sampling controller: the controller
// state encoding and the default widths and sample period.
// No ports (package).
// -----------------------------------------------------------------------------
package quad_pkg;

  // Default width of the decoder count and of the pos/vel outputs
  localparam int QUAD_CNT_W          = 32;
  // Default width of the sample period and timer
  localparam int QUAD_PERIOD_W       = 24;
  // Sample period, in clk cycles, in force after reset
  localparam int QUAD_DEFAULT_PERIOD = 1000;

  // Controller states: idle, one-cycle baseline capture, periodic sampling
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } quad_state_t;

endpackage

// File: rtl/quad_tick_gen.sv
// -----------------------------------------------------------------------------
// quad_tick_gen
// Sample timebase. Holds the shadow and active period registers and a
// free-running interval timer, and emits a one-cycle tick on the last cycle
// of each interval. An active period of 0 behaves as 1 (tick every cycle).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   prime         controller is in its baseline-capture cycle
//   run           controller is sampling this cycle
//   period_in     new period value in clk cycles
//   period_load   strobe: latch period_in into the shadow register
//   tick          one-cycle pulse on the last cycle of an interval
// -----------------------------------------------------------------------------
module quad_tick_gen
  import quad_pkg::*;
#(
  parameter int PERIOD_W       = QUAD_PERIOD_W,
  parameter int DEFAULT_PERIOD = QUAD_DEFAULT_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                prime,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                period_load,
  output logic                tick
);

  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] active_period;
  logic [PERIOD_W-1:0] shadow_period;
  logic [PERIOD_W-1:0] last_count;
  logic [PERIOD_W-1:0] next_period;

  // Periods 0 and 1 both end the interval at timer value 0.
  assign last_count = (active_period == '0) ? '0 : active_period - PERIOD_W'(1);
  assign tick       = run && (timer == last_count);

  // A load arriving in the same cycle as a tick or prime is forwarded
  // straight into the active period, so it governs the very next interval.
  assign next_period = period_load ? period_in : shadow_period;

  // Interval timer: counts while sampling, restarts after each tick and is
  // parked at zero whenever the controller is not sampling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (run && !tick) begin
      timer <= timer + PERIOD_W'(1);
    end else begin
      timer <= '0;
    end
  end

  // Shadow period accepts a new value at any time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_period <= PERIOD_W'(DEFAULT_PERIOD);
    end else if (period_load) begin
      shadow_period <= period_in;
    end
  end

  // Active period only changes on an interval boundary, so an interval in
  // progress is never shortened or stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_period <= PERIOD_W'(DEFAULT_PERIOD);
    end else if (prime || tick) begin
      active_period <= next_period;
    end
  end

endmodule

// File: rtl/quad_sample_ctrl.sv
// -----------------------------------------------------------------------------
// quad_sample_ctrl
// Periodic sampling controller for the quadrature decoder's position counter.
// On each timebase tick it snapshots the position, computes the signed
// position change since the previous tick (velocity) and offers the pair to
// the consumer over a valid/ready handshake, flagging overruns.
//
// Build option: define QUAD_VEL_AVG_EN to report the average of the last four
// deltas instead of the raw delta (history cleared at the start of sampling).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         level: 1 = sampling active
//   period_in      new sample period in clk cycles
//   period_load    strobe: latch period_in into the shadow period
//   count_in       position count from the decoder (same clock domain)
//   pos_out        snapshotted position
//   vel_out        signed delta (two's complement) over the last period
//   sample_valid   pos_out/vel_out hold an unconsumed sample
//   sample_ready   consumer accepts the sample when high with sample_valid
//   overrun        sticky: a sample was overwritten before acceptance
//   busy           high while priming or sampling
// -----------------------------------------------------------------------------
module quad_sample_ctrl
  import quad_pkg::*;
#(
  parameter int CNT_W          = QUAD_CNT_W,
  parameter int PERIOD_W       = QUAD_PERIOD_W,
  parameter int DEFAULT_PERIOD = QUAD_DEFAULT_PERIOD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic                period_load,
  input  logic [CNT_W-1:0]    count_in,
  output logic [CNT_W-1:0]    pos_out,
  output logic [CNT_W-1:0]    vel_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  output logic                busy
);

  quad_state_t      state;
  quad_state_t      state_next;
  logic             prime;
  logic             run;
  logic             tick;
  logic [CNT_W-1:0] prev_count;
  logic [CNT_W-1:0] delta;
  logic [CNT_W-1:0] vel_next;

  quad_tick_gen #(
    .PERIOD_W       (PERIOD_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) u_tick_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .prime       (prime),
    .run         (run),
    .period_in   (period_in),
    .period_load (period_load),
    .tick        (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-state qualifiers. Dropping enable overrides every
  // state, so prime/run are never asserted in a cycle with enable low.
  always_comb begin
    state_next = state;
    prime      = 1'b0;
    run        = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_PRIME;
        ST_PRIME: begin
          prime      = 1'b1;
          state_next = ST_RUN;
        end
        ST_RUN:   run = 1'b1;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  // Modulo-2^CNT_W subtraction gives the correct signed delta across
  // decoder wrap-around in either direction.
  assign delta = count_in - prev_count;

`ifdef QUAD_VEL_AVG_EN
  logic [CNT_W-1:0]        hist1;
  logic [CNT_W-1:0]        hist2;
  logic [CNT_W-1:0]        hist3;
  logic signed [CNT_W+1:0] avg_sum;

  // Two guard bits hold the sum of four signed deltas exactly.
  assign avg_sum = $signed({{2{delta[CNT_W-1]}}, delta})
                 + $signed({{2{hist1[CNT_W-1]}}, hist1})
                 + $signed({{2{hist2[CNT_W-1]}}, hist2})
                 + $signed({{2{hist3[CNT_W-1]}}, hist3});
  assign vel_next = CNT_W'(avg_sum >>> 2);

  // Delta history for the averaging filter, restarted from zero at prime.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1 <= '0;
      hist2 <= '0;
      hist3 <= '0;
    end else if (prime) begin
      hist1 <= '0;
      hist2 <= '0;
      hist3 <= '0;
    end else if (tick) begin
      hist1 <= delta;
      hist2 <= hist1;
      hist3 <= hist2;
    end
  end
`else
  assign vel_next = delta;
`endif

  // Baseline for the next delta: captured at prime and on every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_count <= '0;
    end else if (prime || tick) begin
      prev_count <= count_in;
    end
  end

  // Sample registers, handshake and overrun. Heading to IDLE discards any
  // pending sample and the overrun flag but keeps the last pos/vel values.
  // A tick always loads fresh data; it counts as an overrun only if the old
  // sample was still unconsumed in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_out      <= '0;
      vel_out      <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (state_next == ST_IDLE) begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (tick) begin
      pos_out      <= count_in;
      vel_out      <= vel_next;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_sample_ctrl.sv
// -----------------------------------------------------------------------------
// tb_quad_sample_ctrl
// Self-checking bench for quad_sample_ctrl. A behavioural reference model
// (interval countdown, queue of past deltas) predicts every output on every
// cycle; a table of wrap-around vectors and hand-written sequences check the
// documented corner cases against fixed constants.
// Honours QUAD_VEL_AVG_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_quad_sample_ctrl;

  localparam int CNT_W          = 32;
  localparam int PERIOD_W       = 24;
  localparam int DEFAULT_PERIOD = 1000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic [PERIOD_W-1:0] period_in;
  logic                period_load;
  logic [CNT_W-1:0]    count_in;
  logic [CNT_W-1:0]    pos_out;
  logic [CNT_W-1:0]    vel_out;
  logic                sample_valid;
  logic                sample_ready;
  logic                overrun;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quad_sample_ctrl #(
    .CNT_W          (CNT_W),
    .PERIOD_W       (PERIOD_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .period_in    (period_in),
    .period_load  (period_load),
    .count_in     (count_in),
    .pos_out      (pos_out),
    .vel_out      (vel_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  // Reference model state
  bit                  m_on;
  bit                  m_priming;
  bit                  m_valid;
  bit                  m_ovr;
  int                  m_remaining;
  logic [PERIOD_W-1:0] m_shadow;
  logic [CNT_W-1:0]    m_prev;
  logic [CNT_W-1:0]    m_pos;
  logic [CNT_W-1:0]    m_vel;
`ifdef QUAD_VEL_AVG_EN
  logic [CNT_W-1:0]    m_hist[$];
`endif

  // Wrap-around vectors: count at baseline, count at the tick, expected vel
  typedef struct {
    logic [CNT_W-1:0] c_prev;
    logic [CNT_W-1:0] c_tick;
    logic [CNT_W-1:0] exp_vel;
  } delta_vec_t;

  delta_vec_t vecs[6];

  function automatic int eff_len(logic [PERIOD_W-1:0] p);
    return (p == '0) ? 1 : int'(p);
  endfunction

  function automatic logic [CNT_W-1:0] model_vel(logic [CNT_W-1:0] d);
`ifdef QUAD_VEL_AVG_EN
    longint sum = 0;
    m_hist.push_front(d);
    if (m_hist.size() > 4) void'(m_hist.pop_back());
    foreach (m_hist[i]) sum += longint'($signed(m_hist[i]));
    return CNT_W'(sum >>> 2);
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    m_on        = 1'b0;
    m_priming   = 1'b0;
    m_valid     = 1'b0;
    m_ovr       = 1'b0;
    m_remaining = 0;
    m_shadow    = PERIOD_W'(DEFAULT_PERIOD);
    m_prev      = '0;
    m_pos       = '0;
    m_vel       = '0;
`ifdef QUAD_VEL_AVG_EN
    m_hist.delete();
`endif
  endtask

  // One clock edge of the reference model, using the inputs seen at the edge.
  task automatic model_step();
    logic [PERIOD_W-1:0] nxt;
    nxt = period_load ? period_in : m_shadow;
    if (!enable) begin
      m_on      = 1'b0;
      m_priming = 1'b0;
      m_valid   = 1'b0;
      m_ovr     = 1'b0;
    end else if (m_priming) begin
      m_prev      = count_in;
      m_remaining = eff_len(nxt);
`ifdef QUAD_VEL_AVG_EN
      m_hist.delete();
`endif
      m_priming   = 1'b0;
      m_on        = 1'b1;
    end else if (m_on) begin
      if (m_remaining == 1) begin
        if (m_valid && !sample_ready) m_ovr = 1'b1;
        m_vel       = model_vel(count_in - m_prev);
        m_pos       = count_in;
        m_prev      = count_in;
        m_valid     = 1'b1;
        m_remaining = eff_len(nxt);
      end else begin
        m_remaining--;
        if (m_valid && sample_ready) m_valid = 1'b0;
      end
    end else begin
      m_priming = 1'b1;
    end
    if (period_load) m_shadow = period_in;
  endtask

  task automatic checkOutput(string name, logic [CNT_W-1:0] act, logic [CNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    checkOutput("model_pos",     pos_out,      m_pos);
    checkOutput("model_vel",     vel_out,      m_vel);
    checkOutput("model_valid",   sample_valid, m_valid);
    checkOutput("model_overrun", overrun,      m_ovr);
    checkOutput("model_busy",    busy,         m_on || m_priming);
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare just after.
  task automatic applyStimulus(input logic en, input logic pl, input logic [PERIOD_W-1:0] pin,
                               input logic [CNT_W-1:0] cin, input logic rdy);
    enable       = en;
    period_load  = pl;
    period_in    = pin;
    count_in     = cin;
    sample_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    checkModel();
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    checkModel();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] saved;
    int n;
    int cyc;
    int last_evt;
    int n_samp;
    logic en, pl, rdy;
    logic [PERIOD_W-1:0] pin;

    vecs[0] = '{32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0005};
    vecs[1] = '{32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFB};
    vecs[2] = '{32'd100,       32'd112,       32'd12};
    vecs[3] = '{32'd5,         32'd5,         32'd0};
    vecs[4] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001};
`ifdef QUAD_VEL_AVG_EN
    // With an empty history the first output is the delta divided by four.
    vecs[0].exp_vel = 32'h0000_0001;
    vecs[1].exp_vel = 32'hFFFF_FFFE;
    vecs[2].exp_vel = 32'h0000_0003;
    vecs[3].exp_vel = 32'h0000_0000;
    vecs[4].exp_vel = 32'hE000_0000;
    vecs[5].exp_vel = 32'h0000_0000;
`endif

    enable       = 1'b0;
    period_load  = 1'b0;
    period_in    = '0;
    count_in     = '0;
    sample_ready = 1'b0;

    $display("[TB] reset state");
    do_reset();
    checkOutput("reset_busy",  busy,         1'b0);
    checkOutput("reset_valid", sample_valid, 1'b0);

    $display("[TB] default period latency");
    applyStimulus(1'b1, 1'b0, '0, 32'd5, 1'b0);
    checkOutput("prime_busy", busy, 1'b1);
    n = 0;
    while (!sample_valid && n < 1100) begin
      applyStimulus(1'b1, 1'b0, '0, 32'd5, 1'b0);
      n++;
    end
    checkOutput("first_latency", n, 1001);
    checkOutput("first_pos", pos_out, 32'd5);
    checkOutput("first_vel", vel_out, 32'd0);

    $display("[TB] period reload and ramp");
    do_reset();
    applyStimulus(1'b0, 1'b1, 24'd6, 32'd100, 1'b1);
    cnt = 32'd100; cyc = 0; last_evt = 0; n_samp = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, (i == 3), 24'd4, cnt, 1'b1);
      cnt += 32'd3;
      cyc++;
      if (sample_valid) begin
        n_samp++;
        if (n_samp >= 5) begin
          checkOutput("ramp_vel", vel_out, 32'd12);
          checkOutput("ramp_gap", cyc - last_evt, 4);
        end
        last_evt = cyc;
      end
    end
    checkOutput("ramp_samples", n_samp, 14);

    $display("[TB] wrap-around vectors");
    foreach (vecs[v]) begin
      do_reset();
      applyStimulus(1'b0, 1'b1, 24'd2, vecs[v].c_prev, 1'b1);
      applyStimulus(1'b1, 1'b0, '0, vecs[v].c_prev, 1'b1);
      applyStimulus(1'b1, 1'b0, '0, vecs[v].c_prev, 1'b1);
      n = 0;
      while (!sample_valid && n < 8) begin
        applyStimulus(1'b1, 1'b0, '0, vecs[v].c_tick, 1'b1);
        n++;
      end
      checkOutput("vec_tick_cycles", n, 2);
      checkOutput("vec_pos", pos_out, vecs[v].c_tick);
      checkOutput("vec_vel", vel_out, vecs[v].exp_vel);
    end

    $display("[TB] overrun sequence");
    do_reset();
    applyStimulus(1'b0, 1'b1, 24'd2, 32'd0, 1'b0);
    cnt = 32'd50;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, '0, cnt, 1'b0);
      cnt++;
    end
    checkOutput("ovr_tick1_valid", sample_valid, 1'b1);
    checkOutput("ovr_tick1_flag",  overrun,      1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, '0, cnt, 1'b0);
      cnt++;
    end
    checkOutput("ovr_tick2_flag", overrun, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, cnt, 1'b0);
    cnt++;
    saved = cnt;
    applyStimulus(1'b1, 1'b0, '0, cnt, 1'b0);
    cnt++;
    checkOutput("ovr_latest_pos", pos_out, saved);
    applyStimulus(1'b1, 1'b0, '0, cnt, 1'b1);
    cnt++;
    checkOutput("ovr_accept_valid", sample_valid, 1'b0);
    checkOutput("ovr_accept_flag",  overrun,      1'b1);
    applyStimulus(1'b1, 1'b0, '0, cnt, 1'b1);
    cnt++;
    checkOutput("ovr_sticky_flag", overrun, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, cnt, 1'b1);
    checkOutput("ovr_cleared", overrun, 1'b0);

    $display("[TB] period 1 streaming");
    do_reset();
    applyStimulus(1'b0, 1'b1, 24'd1, 32'd0, 1'b1);
    cnt = 32'd1000;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 1'b0, '0, cnt, 1'b1);
      if (i >= 2) begin
        checkOutput("stream_valid", sample_valid, 1'b1);
        checkOutput("stream_ovr",   overrun,      1'b0);
        checkOutput("stream_pos",   pos_out,      cnt);
      end
      cnt += 32'd7;
    end

`ifdef QUAD_VEL_AVG_EN
    $display("[TB] velocity averaging");
    do_reset();
    applyStimulus(1'b0, 1'b1, 24'd2, 32'd0, 1'b1);
    cnt = 32'd200; n_samp = 0; n = 0;
    while (n_samp < 4 && n < 20) begin
      applyStimulus(1'b1, 1'b0, '0, cnt, 1'b1);
      cnt += 32'd4;
      n++;
      if (sample_valid) begin
        n_samp++;
        checkOutput("avg_vel", vel_out, 32'(2 * n_samp));
      end
    end
    checkOutput("avg_samples", n_samp, 4);
`endif

    $display("[TB] enable drop and mid-period reset");
    do_reset();
    applyStimulus(1'b0, 1'b1, 24'd3, 32'd0, 1'b0);
    cnt = 32'd10;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 1'b0, '0, cnt, 1'b0);
      cnt += 32'd2;
    end
    saved = pos_out;
    applyStimulus(1'b0, 1'b0, '0, cnt, 1'b0);
    checkOutput("drop_busy",  busy,         1'b0);
    checkOutput("drop_valid", sample_valid, 1'b0);
    checkOutput("drop_pos",   pos_out,      saved);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, '0, cnt, 1'b0);
      cnt += 32'd2;
    end
    do_reset();
    checkOutput("midreset_valid", sample_valid, 1'b0);
    checkOutput("midreset_pos",   pos_out,      32'd0);

    $display("[TB] randomized run");
    do_reset();
    cnt = $urandom();
    applyStimulus(1'b0, 1'b1, 24'd3, cnt, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        applyStimulus(1'b0, 1'b1, PERIOD_W'($urandom_range(0, 6)), cnt, 1'b0);
      end
      en  = 1'($urandom_range(0, 29) != 0);
      pl  = 1'($urandom_range(0, 11) == 0);
      pin = PERIOD_W'($urandom_range(0, 6));
      rdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) cnt = $urandom();
      else cnt = cnt + CNT_W'($urandom_range(0, 9)) - 32'd4;
      applyStimulus(en, pl, pin, cnt, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
